// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage redirect pipeline.
// Build option: define PIPE_PERF_CNT_EN to enable the stall_cycles counter.
module pipe_hazard_ctrl #(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_mdu_rd,
   input  logic [4:0]  ex_wr_reg,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        ex_mdu_start,
   input  logic        wb_halt,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_clr,
   output logic        idex_clr,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        mdu_busy,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MDU_LAT - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic             MULTI  = (MDU_LAT > 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] mdu_cnt, cnt_nx;
   logic             lu, mr, st;

   assign lu = ex_is_load && (ex_wr_reg != 5'd0) &&
               ((id_use_rs && (id_rs == ex_wr_reg)) ||
                (id_use_rt && (id_rt == ex_wr_reg)));
   assign mr = (state == MDU_WAIT) && id_mdu_rd;
   assign st = (lu || mr) && !ex_redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         mdu_cnt <= '0;
      end else begin
         state   <= state_nx;
         mdu_cnt <= cnt_nx;
      end
   end

   // Counter holds the MDU_WAIT cycles still to go, so busy lasts MDU_LAT cycles.
   always_comb begin
      state_nx = state;
      cnt_nx   = mdu_cnt;
      unique case (state)
         RUN: begin
            if (wb_halt) begin
               state_nx = HALT;
            end else if (ex_mdu_start && MULTI) begin
               state_nx = MDU_WAIT;
               cnt_nx   = RELOAD;
            end
         end
         MDU_WAIT: begin
            if (wb_halt) begin
               state_nx = HALT;
            end else if (ex_mdu_start) begin
               cnt_nx = RELOAD;
            end else if (mdu_cnt <= ONE) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = mdu_cnt - ONE;
            end
         end
         HALT: begin
            state_nx = HALT;
         end
         default: begin
            state_nx = RUN;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      ifid_clr = 1'b0;
      idex_clr = 1'b0;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      mdu_busy = 1'b0;
      priority case (1'b1)
         rst: begin
         end
         (state == HALT): begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end
         default: begin
            pc_en    = !st;
            ifid_en  = !st;
            ifid_clr = ex_redirect;
            idex_clr = ex_redirect || st;
            mdu_busy = (state == MDU_WAIT) || ex_mdu_start;
         end
      endcase
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if ((state != HALT) && !pc_en) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule
